// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths, reset vector and the fetch-stage
// state encoding.
package cpu_defs;

    localparam int              ADDR_W       = 16;
    localparam int              DATA_W       = 16;
    localparam logic [15:0]     RESET_VECTOR = 16'h0000;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_INCR   = 3'd1;
    localparam logic [2:0] ST_LOAD   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_HALTED = 3'd4;

    typedef enum logic [2:0] {
        FETCH  = ST_FETCH,
        INCR   = ST_INCR,
        LOAD   = ST_LOAD,
        DRAIN  = ST_DRAIN,
        HALTED = ST_HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Saturating 8-bit wait counter for instruction-memory reads; flags the wait
// cycle that would bring the count up to the programmed limit.
module fetch_timeout_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clr) begin
            count <= 8'd0;
        end else if (en && count != 8'hFF) begin
            count <= count + 8'd1;
        end
    end

    // Combinational so the halt lands on the same edge the limit is reached.
    assign expired = en && ({1'b0, count} + 9'd1 >= {1'b0, limit});

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues memory reads, buffers one
// instruction for decode and sequences the external PC adder.
module instr_fetch #(
    parameter int                ADDR_W       = cpu_defs::ADDR_W,
    parameter int                DATA_W       = cpu_defs::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(cpu_defs::RESET_VECTOR),
    parameter int                TIMEOUT      = 15
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc_addr,
    output logic              inc_req,
    input  logic [ADDR_W-1:0] pc_next_addr,
    output logic              mem_req,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              halt,
    input  logic              stall,
    output logic              fetch_err
);

    import cpu_defs::*;

    fetch_state_t state, state_next;

    logic capture;
    logic waiting;
    logic ctr_clr;
    logic expired;
    logic take_word;
    logic load_next;
    logic load_target;
    logic set_err;

    always_comb begin
        mem_req = (state == FETCH) && !stall;
        inc_req = (state == INCR);
        capture = mem_req && mem_ready;
        waiting = mem_req && !mem_ready;
        ctr_clr = (state != FETCH) || capture || branch_taken;
    end

    fetch_timeout_ctr u_timeout (
        .clk     (clk),
        .rst     (rst),
        .en      (waiting),
        .clr     (ctr_clr),
        .limit   (8'(TIMEOUT)),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        take_word   = 1'b0;
        load_next   = 1'b0;
        load_target = 1'b0;
        set_err     = 1'b0;
        if (state != HALTED) begin
            if (halt) begin
                state_next = HALTED;
            end else if (expired) begin
                state_next = HALTED;
                set_err    = 1'b1;
            end else if (branch_taken) begin
                state_next  = FETCH;
                load_target = 1'b1;
            end else begin
                unique case (state)
                    FETCH: if (capture) begin
                        state_next = INCR;
                        take_word  = 1'b1;
                    end
                    INCR:  state_next = LOAD;
                    LOAD: begin
                        state_next = DRAIN;
                        load_next  = 1'b1;
                    end
                    DRAIN: if (!ir_valid || ir_ack) state_next = FETCH;
                    default: state_next = FETCH;
                endcase
            end
        end
    end

    // Capture beats the acknowledge clear; a redirect discards the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_addr   <= RESET_VECTOR;
            ir        <= '0;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            if (load_target)    pc_addr <= branch_target;
            else if (load_next) pc_addr <= pc_next_addr;

            if (take_word) ir <= mem_rdata;

            if (take_word)                          ir_valid <= 1'b1;
            else if (load_target)                   ir_valid <= 1'b0;
            else if (ir_valid && ir_ack)            ir_valid <= 1'b0;

            if (set_err) fetch_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench: two fetch stages (TIMEOUT 15 and 2) on shared stimulus,
// each with its own PC adder, compared every cycle against a behavioural model.
module tb_instr_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, halt, branch_taken, stall, mem_ready, ir_ack;
    logic [15:0] branch_target, mem_rdata;

    logic [15:0] pc_a, next_a, ir_a, pc_b, next_b, ir_b;
    logic        inc_a, req_a, irv_a, err_a, inc_b, req_b, irv_b, err_b;
    logic [15:0] adder_a = 16'd0;
    logic [15:0] adder_b = 16'd0;

    assign next_a = adder_a;
    assign next_b = adder_b;

    // External PC adders: result is registered one cycle after the pulse.
    always @(posedge clk) begin
        if (inc_a) adder_a <= pc_a + 16'd1;
        if (inc_b) adder_b <= pc_b + 16'd1;
    end

    instr_fetch #(.TIMEOUT(15)) dut_a (
        .clk(clk), .rst(rst), .pc_addr(pc_a), .inc_req(inc_a), .pc_next_addr(next_a),
        .mem_req(req_a), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ir(ir_a),
        .ir_valid(irv_a), .ir_ack(ir_ack), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt(halt), .stall(stall), .fetch_err(err_a)
    );

    instr_fetch #(.TIMEOUT(2)) dut_b (
        .clk(clk), .rst(rst), .pc_addr(pc_b), .inc_req(inc_b), .pc_next_addr(next_b),
        .mem_req(req_b), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ir(ir_b),
        .ir_valid(irv_b), .ir_ack(ir_ack), .branch_taken(branch_taken),
        .branch_target(branch_target), .halt(halt), .stall(stall), .fetch_err(err_b)
    );

    // Reference model: phase counts cycles since the last capture (0 = fetching).
    typedef struct {
        logic [15:0] pc;
        logic [15:0] ir;
        bit          ir_valid;
        bit          err;
        bit          halted;
        int          phase;
        int          waited;
    } model_t;

    model_t ma, mb;
    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic model_t model_reset();
        model_t m;
        m.pc = 16'h0000; m.ir = 16'h0000; m.ir_valid = 0; m.err = 0;
        m.halted = 0; m.phase = 0; m.waited = 0;
        return m;
    endfunction

    function automatic bit model_req(model_t m);
        return !m.halted && m.phase == 0 && !stall;
    endfunction

    function automatic bit model_inc(model_t m);
        return !m.halted && m.phase == 1;
    endfunction

    function automatic model_t model_step(model_t m, int timeout, logic [15:0] next_addr);
        model_t n = m;
        bit req = model_req(m);
        if (rst) return model_reset();
        if (m.ir_valid && ir_ack) n.ir_valid = 0;
        if (m.halted) return n;
        if (halt) begin
            n.halted = 1; n.waited = 0;
            return n;
        end
        if (req && !mem_ready && m.waited + 1 >= timeout) begin
            n.err = 1; n.halted = 1; n.waited = 0;
            return n;
        end
        if (branch_taken) begin
            n.pc = branch_target; n.ir_valid = 0; n.phase = 0; n.waited = 0;
            return n;
        end
        case (m.phase)
            0: if (req && mem_ready) begin
                   n.ir = mem_rdata; n.ir_valid = 1; n.phase = 1; n.waited = 0;
               end else if (req) begin
                   n.waited = m.waited + 1;
               end
            1: n.phase = 2;
            2: begin n.pc = next_addr; n.phase = 3; end
            3: if (!m.ir_valid || ir_ack) n.phase = 0;
            default: ;
        endcase
        return n;
    endfunction

    task automatic compare(input string who, input model_t m, input logic [15:0] pc,
                           input logic req, input logic inc, input logic [15:0] ir,
                           input logic irv, input logic err);
        check({who, ".pc_addr"},   32'(pc),  32'(m.pc));
        check({who, ".mem_req"},   32'(req), 32'(model_req(m)));
        check({who, ".inc_req"},   32'(inc), 32'(model_inc(m)));
        check({who, ".ir"},        32'(ir),  32'(m.ir));
        check({who, ".ir_valid"},  32'(irv), 32'(m.ir_valid));
        check({who, ".fetch_err"}, 32'(err), 32'(m.err));
    endtask

    task automatic tick();
        model_t na, nb;
        @(negedge clk);
        compare("a", ma, pc_a, req_a, inc_a, ir_a, irv_a, err_a);
        compare("b", mb, pc_b, req_b, inc_b, ir_b, irv_b, err_b);
        na = model_step(ma, 15, adder_a);
        nb = model_step(mb, 2, adder_b);
        @(posedge clk);
        #1;
        ma = na;
        mb = nb;
        cyc++;
    endtask

    task automatic drive(input bit r, input bit h, input bit br, input logic [15:0] tgt,
                         input bit st, input bit rdy, input bit ack);
        rst = r; halt = h; branch_taken = br; branch_target = tgt;
        stall = st; mem_ready = rdy; ir_ack = ack;
        mem_rdata = 16'($urandom);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 16'h0, 0, 0, 1);
        tick();
    endtask

    initial begin
        drive(1, 0, 0, 16'h0, 0, 0, 1);
        @(posedge clk);
        #1;
        ma = model_reset();
        mb = model_reset();

        // Reset state and zero-wait free run.
        check("reset.pc_addr", 32'(pc_a), 32'h0);
        check("reset.ir", 32'(ir_a), 32'h0);
        check("reset.ir_valid", 32'(irv_a), 32'h0);
        check("reset.fetch_err", 32'(err_a), 32'h0);
        check("reset.inc_req", 32'(inc_a), 32'h0);
        tick();
        for (int c = 0; c < 14; c++) begin
            drive(0, 0, 0, 16'h0, 0, 1, 1);
            if (c == 0) check("run.first_mem_req", 32'(req_a), 32'h1);
            check("run.pc_seq", 32'(pc_a), 32'((c + 1) / 4));
            check("run.inc_pulse", 32'(inc_a), 32'(c % 4 == 1));
            tick();
        end

        // Three wait states: TIMEOUT 15 captures, TIMEOUT 2 errors out.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(0, 0, 0, 16'h0, 0, 0, 1);
            if (c == 2) begin
                check("wait.b_err", 32'(err_b), 32'h1);
                check("wait.b_req", 32'(req_b), 32'h0);
                check("wait.a_req", 32'(req_a), 32'h1);
            end
            tick();
        end
        drive(0, 0, 0, 16'h0, 0, 1, 0);
        tick();
        check("wait.a_captured", 32'(irv_a), 32'h1);
        check("wait.a_err", 32'(err_a), 32'h0);
        for (int c = 0; c < 6; c++) begin
            drive(0, 0, 0, 16'h0, 0, 1, 1);
            check("wait.b_req_off", 32'(req_b), 32'h0);
            tick();
        end

        // Branch during the LOAD of PC 0005.
        do_reset();
        for (int c = 0; c < 22; c++) begin
            drive(0, 0, 0, 16'h0, 0, 1, 1);
            tick();
        end
        check("branch.pc_before", 32'(pc_a), 32'h5);
        drive(0, 0, 1, 16'h0040, 0, 1, 1);
        tick();
        check("branch.pc_after", 32'(pc_a), 32'h40);
        check("branch.ir_valid", 32'(irv_a), 32'h0);
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 0, 16'h0, 0, 1, 1);
            check("branch.no_stale", 32'(pc_a == 16'h0006), 32'h0);
            tick();
        end

        // Decode back-pressure holds the stage in DRAIN.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            drive(0, 0, 0, 16'h0, 0, 1, c == 8);
            if (c >= 3) check("drain.mem_req", 32'(req_a), 32'h0);
            tick();
        end
        check("drain.resume", 32'(req_a), 32'h1);

        // Halt in FETCH, then reset out of HALTED.
        do_reset();
        drive(0, 1, 1, 16'h1234, 0, 0, 1);
        check("halt.req_before", 32'(req_a), 32'h1);
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 16'h0, 0, 1, 1);
            check("halt.req_off", 32'(req_a), 32'h0);
            check("halt.pc_kept", 32'(pc_a), 32'h0);
            tick();
        end
        do_reset();
        check("halt.rst_pc", 32'(pc_a), 32'h0);
        check("halt.rst_ir_valid", 32'(irv_a), 32'h0);
        check("halt.rst_err", 32'(err_b), 32'h0);
        drive(0, 0, 0, 16'h0, 0, 1, 1);
        check("halt.resume_req", 32'(req_a), 32'h1);
        tick();
        check("halt.resume_fetch", 32'(irv_a), 32'h1);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 199) < 3, $urandom_range(0, 99) < 1,
                  $urandom_range(0, 99) < 5, 16'($urandom),
                  $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 60);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
